// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Executes decoded load/store commands from the EX/MEM stage on a req/ack
//   data-memory bus, stalls the pipeline while busy and returns aligned,
//   sign-extended load data together with a fault code.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start                       one-cycle command strobe (sampled in IDLE only)
//   mem_read, mem_write         decoded load / store
//   size                        00 = word, 11 = halfword, others illegal
//   dec_exc                     decoder exception
//   addr, wdata                 byte address and store data
//   stall                       high while a command is in progress
//   done                        one-cycle completion pulse
//   rdata, fault                load result and fault code, valid with done
//                               (fault: 00 ok, 01 misaligned, 10 timeout, 11 decode)
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata           data-memory request side
//   bus_ack, bus_rdata          data-memory response side
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              dec_exc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [1:0]        fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_t;

    // Pick the addressed lane of a bus word; halfwords are sign-extended.
    function automatic logic [31:0] load_align(input logic half, input logic upper,
                                               input logic [31:0] word);
        logic signed [15:0] h;
        logic signed [31:0] ext;
        h   = $signed(upper ? word[31:16] : word[15:0]);
        ext = h;
        return half ? $unsigned(ext) : word;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              exc_q, exc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cnt_inc;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        fault_q, fault_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              half;

    assign half    = (size_q == 2'b11);
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        exc_d       = exc_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                // Non-memory instructions (neither read nor write) are dropped.
                if (start && (mem_read || mem_write)) begin
                    state_d = S_CHECK;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = mem_write;
                    size_d  = size;
                    // Read and write together is a malformed decode.
                    exc_d   = dec_exc | (mem_read & mem_write);
                    rdata_d = '0;
                    fault_d = 2'b00;
                end
            end
            S_CHECK: begin
                if (exc_q || size_q == 2'b01 || size_q == 2'b10) begin
                    fault_d = 2'b11;
                    state_d = S_DONE;
                end else if (half ? addr_q[0] : (addr_q[1:0] != 2'b00)) begin
                    fault_d = 2'b01;
                    state_d = S_DONE;
                end else begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = we_q;
                    bus_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
                    bus_be_d    = half ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                    // Halfword store data goes to both lanes; bus_be picks one.
                    bus_wdata_d = half ? {2{wdata_q[15:0]}} : wdata_q;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // Ack is tested first so an ack on the last allowed cycle succeeds.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    rdata_d   = we_q ? 32'd0 : load_align(half, addr_q[1], bus_rdata);
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(TIMEOUT)) begin
                        bus_req_d = 1'b0;
                        fault_d   = 2'b10;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            exc_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            exc_q       <= exc_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign stall     = (state_q == S_CHECK) || (state_q == S_REQ);
    assign done      = (state_q == S_DONE);
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit: directed scenarios plus
//   randomized commands compared against a behavioural model.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset, start, mem_read, mem_write, dec_exc;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        stall, done, bus_req, bus_we, bus_ack;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  fault;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .dec_exc(dec_exc), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // Observations of one command, from start strobe to done (+1 hold cycle).
    int          o_lat, o_reqs;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [1:0]  o_fault;
    logic [3:0]  o_be;
    logic        o_we, o_stable, o_ctl_ok, o_hold_ok;

    // Behavioural expectation of one command.
    int          e_lat, e_reqs;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [1:0]  e_fault;
    logic [3:0]  e_be;

    task automatic model(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic ex, input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rdat);
        bit          hw;
        int unsigned h;
        hw      = (sz == 2'd3);
        e_rdata = 0;
        e_reqs  = 0;
        e_be    = hw ? (((a % 4) >= 2) ? 4'hC : 4'h3) : 4'hF;
        e_addr  = a - (a % 4);
        e_wdata = hw ? (wd % 65536) * 32'h10001 : wd;
        if (ex || (rd && wr) || sz == 2'd1 || sz == 2'd2) begin
            e_fault = 2'd3; e_lat = 2;
        end else if (hw ? (a % 2 != 0) : (a % 4 != 0)) begin
            e_fault = 2'd1; e_lat = 2;
        end else if (ack_at < 1 || ack_at > TO) begin
            e_fault = 2'd2; e_lat = 2 + TO; e_reqs = TO;
        end else begin
            e_fault = 2'd0; e_lat = 2 + ack_at; e_reqs = ack_at;
            if (!wr) begin
                if (!hw) e_rdata = rdat;
                else begin
                    h = ((a % 4) >= 2) ? rdat / 65536 : rdat % 65536;
                    e_rdata = (h >= 32768) ? h + 32'hFFFF0000 : h;
                end
            end
        end
    endtask

    // Issue one command and act as the memory: ack on the ack_at-th REQ cycle
    // (0 = never). With noise set, an ack is also driven during CHECK.
    task automatic run_cmd(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic ex, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdat, input logic noise);
        start = 1'b1; mem_read = rd; mem_write = wr; size = sz; dec_exc = ex;
        addr = a; wdata = wd; bus_ack = 1'b0;
        o_lat = -1; o_reqs = 0; o_stable = 1'b1; o_ctl_ok = 1'b1;
        o_rdata = '0; o_fault = '0; o_be = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = 1'b0; bus_ack = 1'b0;
            if (done) begin
                o_lat = c; o_rdata = rdata; o_fault = fault;
                if (stall || bus_req) o_ctl_ok = 1'b0;
                break;
            end
            if (!stall) o_ctl_ok = 1'b0;
            if (bus_req) begin
                o_reqs++;
                if (o_reqs == 1) begin
                    o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
                end else if (o_be !== bus_be || o_addr !== bus_addr ||
                             o_wdata !== bus_wdata || o_we !== bus_we) begin
                    o_stable = 1'b0;
                end
                if (o_reqs == ack_at) begin
                    bus_ack = 1'b1; bus_rdata = rdat;
                end
            end else if (c == 1 && noise) begin
                bus_ack = 1'b1; bus_rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        o_hold_ok = (rdata === o_rdata) && (fault === o_fault) && !done && !stall;
    endtask

    task automatic test_reset();
        n_checks++; if ({stall, done, bus_req, bus_we} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {stall, done, bus_req, bus_we}); else n_pass++;
        n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
        n_checks++; if (fault !== 2'd0) $display("FAIL reset_fault got %0d want 0", fault); else n_pass++;
        n_checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'd0) $display("FAIL reset_bus got %h/%h/%h want 0", bus_addr, bus_wdata, bus_be); else n_pass++;
    endtask

    task automatic test_word_load();
        run_cmd(1, 0, 2'b00, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
        n_checks++; if (o_lat !== 4) $display("FAIL lw_latency got %0d want 4", o_lat); else n_pass++;
        n_checks++; if (o_be !== 4'hF || o_addr !== 32'h100 || o_we !== 1'b0) $display("FAIL lw_bus got be=%h addr=%h we=%b want be=f addr=100 we=0", o_be, o_addr, o_we); else n_pass++;
        n_checks++; if (o_rdata !== 32'hDEADBEEF || o_fault !== 2'd0) $display("FAIL lw_result got %h/%0d want deadbeef/0", o_rdata, o_fault); else n_pass++;
        n_checks++; if (!o_ctl_ok || !o_stable || !o_hold_ok) $display("FAIL lw_ctl got ctl=%b stable=%b hold=%b want 111", o_ctl_ok, o_stable, o_hold_ok); else n_pass++;
    endtask

    task automatic test_half_load();
        run_cmd(1, 0, 2'b11, 0, 32'h102, 32'h0, 1, 32'h80011234, 0);
        n_checks++; if (o_be !== 4'hC || o_addr !== 32'h100) $display("FAIL lh_hi_bus got be=%h addr=%h want c/100", o_be, o_addr); else n_pass++;
        n_checks++; if (o_rdata !== 32'hFFFF8001 || o_fault !== 2'd0 || o_lat !== 3) $display("FAIL lh_hi got %h/%0d lat %0d want ffff8001/0 lat 3", o_rdata, o_fault, o_lat); else n_pass++;
        run_cmd(1, 0, 2'b11, 0, 32'h100, 32'h0, 1, 32'h80011234, 0);
        n_checks++; if (o_be !== 4'h3) $display("FAIL lh_lo_be got %h want 3", o_be); else n_pass++;
        n_checks++; if (o_rdata !== 32'h00001234 || o_fault !== 2'd0) $display("FAIL lh_lo got %h/%0d want 00001234/0", o_rdata, o_fault); else n_pass++;
    endtask

    task automatic test_half_store();
        run_cmd(0, 1, 2'b11, 0, 32'h206, 32'h0000ABCD, 3, 32'h55555555, 0);
        n_checks++; if (o_we !== 1'b1 || o_addr !== 32'h204 || o_be !== 4'hC) $display("FAIL sh_bus got we=%b addr=%h be=%h want 1/204/c", o_we, o_addr, o_be); else n_pass++;
        n_checks++; if (o_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); else n_pass++;
        n_checks++; if (o_fault !== 2'd0 || o_rdata !== 32'd0 || o_lat !== 5) $display("FAIL sh_done got %0d/%h lat %0d want 0/0 lat 5", o_fault, o_rdata, o_lat); else n_pass++;
    endtask

    task automatic test_faults();
        run_cmd(1, 0, 2'b00, 0, 32'h101, 32'h0, 1, 32'h0, 0);
        n_checks++; if (o_reqs !== 0 || o_lat !== 2 || o_fault !== 2'd1) $display("FAIL misalign got reqs=%0d lat=%0d fault=%0d want 0/2/1", o_reqs, o_lat, o_fault); else n_pass++;
        run_cmd(1, 0, 2'b00, 1, 32'h100, 32'h0, 1, 32'h0, 1);
        n_checks++; if (o_reqs !== 0 || o_lat !== 2 || o_fault !== 2'd3) $display("FAIL dec_exc got reqs=%0d lat=%0d fault=%0d want 0/2/3", o_reqs, o_lat, o_fault); else n_pass++;
        run_cmd(1, 1, 2'b00, 0, 32'h100, 32'h0, 1, 32'h0, 0);
        n_checks++; if (o_reqs !== 0 || o_fault !== 2'd3) $display("FAIL rd_and_wr got reqs=%0d fault=%0d want 0/3", o_reqs, o_fault); else n_pass++;
        run_cmd(0, 1, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0, 0);
        n_checks++; if (o_reqs !== 0 || o_fault !== 2'd3) $display("FAIL bad_size got reqs=%0d fault=%0d want 0/3", o_reqs, o_fault); else n_pass++;
    endtask

    task automatic test_timeout();
        run_cmd(1, 0, 2'b00, 0, 32'h40, 32'h0, 0, 32'h0, 0);
        n_checks++; if (o_reqs !== TO || o_lat !== TO + 2 || o_fault !== 2'd2) $display("FAIL timeout got reqs=%0d lat=%0d fault=%0d want %0d/%0d/2", o_reqs, o_lat, o_fault, TO, TO + 2); else n_pass++;
        n_checks++; if (o_rdata !== 32'd0) $display("FAIL timeout_rdata got %h want 0", o_rdata); else n_pass++;
        run_cmd(1, 0, 2'b00, 0, 32'h40, 32'h0, TO, 32'h12345678, 0);
        n_checks++; if (o_reqs !== TO || o_fault !== 2'd0 || o_rdata !== 32'h12345678) $display("FAIL ack_last got reqs=%0d fault=%0d rdata=%h want %0d/0/12345678", o_reqs, o_fault, o_rdata, TO); else n_pass++;
    endtask

    task automatic test_ignored();
        logic busy;
        busy = 1'b0;
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            if (stall || done || bus_req) busy = 1'b1;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignored_cmd got activity=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        logic seen_done, nonzero;
        seen_done = 1'b0; nonzero = 1'b0;
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b00; dec_exc = 1'b0; addr = 32'h300;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus_req !== 1'b1) $display("FAIL rst_req_entry got %b want 1", bus_req); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            if (done) seen_done = 1'b1;
            if ({stall, bus_req, bus_we, bus_be, fault} !== 9'd0 || rdata !== 0 || bus_addr !== 0 || bus_wdata !== 0) nonzero = 1'b1;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        n_checks++; if (seen_done !== 1'b0) $display("FAIL rst_no_done got %b want 0", seen_done); else n_pass++;
        n_checks++; if (nonzero !== 1'b0) $display("FAIL rst_outputs got nonzero=%b want 0", nonzero); else n_pass++;
        run_cmd(1, 0, 2'b00, 0, 32'h300, 32'h0, 1, 32'h0BADCAFE, 0);
        n_checks++; if (o_rdata !== 32'h0BADCAFE || o_fault !== 2'd0 || o_lat !== 3) $display("FAIL rst_after got %h/%0d lat %0d want 0badcafe/0 lat 3", o_rdata, o_fault, o_lat); else n_pass++;
    endtask

    task automatic test_random();
        logic        rd, wr, ex, nz;
        logic [1:0]  sz;
        logic [31:0] a, wd, rdat;
        int          ack_at, k;
        for (int it = 0; it < 40; it++) begin
            k  = $urandom_range(0, 9);
            rd = (k < 5) || (k == 9);
            wr = (k >= 5);
            ex = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0, 2:    sz = 2'b00;
                1, 3:    sz = 2'b11;
                4:       sz = 2'b01;
                default: sz = 2'b10;
            endcase
            a = $urandom & 32'h0000FFFF;
            if ($urandom_range(0, 3) != 0) a = a & (sz == 2'b11 ? 32'hFFFFFFFE : 32'hFFFFFFFC);
            wd     = $urandom;
            rdat   = $urandom;
            ack_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
            nz     = $urandom_range(0, 1);
            model(rd, wr, sz, ex, a, wd, ack_at, rdat);
            run_cmd(rd, wr, sz, ex, a, wd, ack_at, rdat, nz);
            n_checks++; if (o_fault !== e_fault || o_lat !== e_lat || o_reqs !== e_reqs) $display("FAIL rnd%0d_ctl got f=%0d lat=%0d reqs=%0d want f=%0d lat=%0d reqs=%0d", it, o_fault, o_lat, o_reqs, e_fault, e_lat, e_reqs); else n_pass++;
            n_checks++; if (o_rdata !== e_rdata) $display("FAIL rnd%0d_rdata got %h want %h", it, o_rdata, e_rdata); else n_pass++;
            n_checks++; if (!o_ctl_ok || !o_stable || !o_hold_ok) $display("FAIL rnd%0d_proto got ctl=%b stable=%b hold=%b want 111", it, o_ctl_ok, o_stable, o_hold_ok); else n_pass++;
            if (e_reqs > 0) begin
                n_checks++; if (o_be !== e_be || o_addr !== e_addr || o_wdata !== e_wdata || o_we !== wr) $display("FAIL rnd%0d_bus got be=%h addr=%h wd=%h we=%b want be=%h addr=%h wd=%h we=%b", it, o_be, o_addr, o_wdata, o_we, e_be, e_addr, e_wdata, wr); else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
        dec_exc = 1'b0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_word_load();
        test_half_load();
        test_half_store();
        test_faults();
        test_timeout();
        test_ignored();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
